// File: rtl/tt_mask_idx_sequencer.sv
// tt_mask_idx_sequencer: streams per-memop mask words or index elements to the VMU under credit flow control
module tt_mask_idx_sequencer #(
    parameter int VLEN         = 256,
    parameter int MASK_W       = 64,
    parameter int IDX_REGS     = 8,
    parameter int MASK_CREDITS = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_is_masked,
    input  logic                      i_is_indexed,
    input  logic                      i_skip_inactive,
    input  logic [$clog2(VLEN+1)-1:0] i_vl,
    input  logic [$clog2(VLEN+1)-1:0] i_vstart,
    input  logic [1:0]                i_eew,
    input  logic [VLEN-1:0]           i_mask_data,
    input  logic [VLEN-1:0]           i_index_data,
    input  logic                      i_index_data_valid,
    input  logic                      i_last_index,
    input  logic                      i_credit,
    input  logic                      i_flush,
    output logic [MASK_W:0]           o_item,
    output logic                      o_valid,
    output logic                      o_last,
    output logic [$clog2(VLEN)-1:0]   o_elem,
    output logic                      o_done,
    output logic                      o_busy,
    output logic                      o_idx_overflow
);
    localparam int VLW = $clog2(VLEN + 1);
    localparam int EW  = $clog2(VLEN);
    localparam int CW  = $clog2(MASK_CREDITS + 2);
    localparam int PW  = $clog2(IDX_REGS + 1);
    localparam int SW  = VLW + 6;
    localparam int IB  = IDX_REGS * VLEN;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   credits_q, credits_d, avail;
    logic            indexed_q, indexed_d, skip_q, skip_d;
    logic [1:0]      eew_q, eew_d;
    logic [VLW-1:0]  vstart_q, vstart_d, count_q, count_d, elem_q, elem_d;
    logic [PW-1:0]   wptr_q, wptr_d, wslot;
    logic [VLEN-1:0] mask_q, mask_d, start_mask, rem;
    logic [IB-1:0]   idx_q, idx_d, idx_wr;
    logic [MASK_W:0] item_q, item_d;
    logic [EW-1:0]   oelem_q, oelem_d;
    logic            valid_q, valid_d, last_q, last_d, done_q, done_d, ovf_q, ovf_d;
    logic            start_ok, accept, room, drop, consume, emit;
    logic [63:0]     idx_w;
    logic [SW-1:0]   sh;

    assign start_ok   = state_q == IDLE && i_start && (i_is_masked || i_is_indexed);
    assign accept     = i_index_data_valid && ((start_ok && i_is_indexed) || state_q == WAIT);
    assign room       = wptr_q < PW'(IDX_REGS);
    assign wslot      = start_ok ? '0 : wptr_q;
    assign start_mask = (i_is_masked ? i_mask_data : '1) & ({VLEN{1'b1}} << i_vstart);
    assign sh         = SW'(state_q == IDLE ? i_vstart : vstart_q) << ({1'b0, state_q == IDLE ? i_eew : eew_q} + 3'd3);
    assign avail      = credits_q + CW'(i_credit);
    assign drop       = skip_q && indexed_q && !mask_q[0];
    assign consume    = state_q == SEND && count_q != '0 && (drop || avail != '0);
    assign emit       = consume && !drop;
    // mask bits of the elements still to come after the current one, for the skip-mode o_last lookahead
    assign rem        = (mask_q >> 1) & ~({VLEN{1'b1}} << (count_q - VLW'(1)));
    assign idx_w      = idx_q[63:0] & ~({64{1'b1}} << (8 << eew_q));

    always_comb begin
        idx_wr = start_ok ? '0 : idx_q;
        if (accept && (start_ok || room)) idx_wr[wslot*VLEN +: VLEN] = i_index_data;
    end

    always_comb begin
        state_d   = state_q;
        credits_d = avail - CW'(emit);
        indexed_d = indexed_q;
        skip_d    = skip_q;
        eew_d     = eew_q;
        vstart_d  = vstart_q;
        count_d   = count_q;
        elem_d    = elem_q;
        wptr_d    = wptr_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        valid_d   = emit;
        item_d    = '0;
        oelem_d   = '0;
        last_d    = emit && (skip_q && indexed_q ? rem == '0 : count_q == VLW'(1));
        done_d    = 1'b0;
        if (start_ok) begin
            indexed_d = i_is_indexed;
            skip_d    = i_skip_inactive;
            eew_d     = i_eew;
            vstart_d  = i_vstart;
            ovf_d     = 1'b0;
            if (i_vstart >= i_vl) begin
                done_d = 1'b1;
            end else begin
                state_d = (i_is_indexed && !i_last_index) ? WAIT : SEND;
                count_d = i_is_indexed ? i_vl - i_vstart
                                       : VLW'((32'(i_vl) + MASK_W - 1) / MASK_W - 32'(i_vstart) / MASK_W);
                elem_d  = i_vstart;
                wptr_d  = PW'(accept);
                mask_d  = i_is_indexed ? start_mask >> i_vstart : start_mask >> (32'(i_vstart) / MASK_W * MASK_W);
                idx_d   = (i_is_indexed && i_last_index) ? idx_wr >> sh : idx_wr;
            end
        end
        if (state_q == WAIT && i_index_data_valid) begin
            wptr_d  = wptr_q + PW'(room);
            ovf_d   = ovf_q || !room;
            state_d = i_last_index ? SEND : WAIT;
            idx_d   = i_last_index ? idx_wr >> sh : idx_wr;
        end
        if (consume) begin
            count_d = count_q - VLW'(1);
            elem_d  = elem_q + VLW'(1);
            mask_d  = indexed_q ? mask_q >> 1 : mask_q >> MASK_W;
            idx_d   = idx_q >> (8 << eew_q);
            item_d  = !emit ? '0 : indexed_q ? {mask_q[0], MASK_W'(idx_w)} : {1'b0, mask_q[MASK_W-1:0]};
            oelem_d = (emit && indexed_q) ? elem_q[EW-1:0] : '0;
            state_d = count_q == VLW'(1) ? IDLE : SEND;
            done_d  = count_q == VLW'(1);
        end
        if (i_flush) begin
            state_d   = IDLE;
            credits_d = avail;
            count_d   = '0;
            elem_d    = '0;
            wptr_d    = '0;
            mask_d    = '0;
            idx_d     = '0;
            ovf_d     = ovf_q;
            valid_d   = 1'b0;
            item_d    = '0;
            oelem_d   = '0;
            last_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            credits_q <= CW'(MASK_CREDITS);
            indexed_q <= 1'b0;
            skip_q    <= 1'b0;
            eew_q     <= '0;
            vstart_q  <= '0;
            count_q   <= '0;
            elem_q    <= '0;
            wptr_q    <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            item_q    <= '0;
            oelem_q   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            indexed_q <= indexed_d;
            skip_q    <= skip_d;
            eew_q     <= eew_d;
            vstart_q  <= vstart_d;
            count_q   <= count_d;
            elem_q    <= elem_d;
            wptr_q    <= wptr_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            item_q    <= item_d;
            oelem_q   <= oelem_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    credit_bound: assert property (@(posedge i_clk) disable iff (i_reset) credits_q <= CW'(MASK_CREDITS));

    assign o_item         = item_q;
    assign o_valid        = valid_q;
    assign o_last         = last_q;
    assign o_elem         = oelem_q;
    assign o_done         = done_q;
    assign o_busy         = state_q != IDLE;
    assign o_idx_overflow = ovf_q;
endmodule

// File: tb/tb_tt_mask_idx_sequencer.sv
// tb_tt_mask_idx_sequencer: scoreboard bench for the mask/index sequencer with a delayed credit returner
module tb_tt_mask_idx_sequencer;
    localparam int VLEN = 256, MASK_W = 64, EW = 8;

    logic              i_clk = 1'b0;
    logic              i_reset, i_start, i_is_masked, i_is_indexed, i_skip_inactive;
    logic [8:0]        i_vl, i_vstart;
    logic [1:0]        i_eew;
    logic [VLEN-1:0]   i_mask_data, i_index_data;
    logic              i_index_data_valid, i_last_index, i_credit, i_flush;
    logic [MASK_W:0]   o_item;
    logic              o_valid, o_last, o_done, o_busy, o_idx_overflow;
    logic [EW-1:0]     o_elem;

    typedef struct {
        logic [MASK_W:0] item;
        logic [EW-1:0]   elem;
        logic            last;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0, done_cnt = 0, vcnt = 0, owed = 0;
    bit         hold = 1'b0;
    logic [1:0] pipe = '0;

    tt_mask_idx_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_is_masked(i_is_masked),
        .i_is_indexed(i_is_indexed), .i_skip_inactive(i_skip_inactive), .i_vl(i_vl),
        .i_vstart(i_vstart), .i_eew(i_eew), .i_mask_data(i_mask_data), .i_index_data(i_index_data),
        .i_index_data_valid(i_index_data_valid), .i_last_index(i_last_index), .i_credit(i_credit),
        .i_flush(i_flush), .o_item(o_item), .o_valid(o_valid), .o_last(o_last), .o_elem(o_elem),
        .o_done(o_done), .o_busy(o_busy), .o_idx_overflow(o_idx_overflow)
    );

    always #5 i_clk = ~i_clk;

    // downstream: returns one credit roughly two cycles after each item unless held
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                owed = 0;
                pipe = '0;
                i_credit = 1'b0;
            end else begin
                pipe = {pipe[0], o_valid === 1'b1};
                owed += int'(pipe[1]);
                if (!hold && owed > 0) begin
                    i_credit = 1'b1;
                    owed--;
                end else begin
                    i_credit = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1) done_cnt++;
            if (o_valid === 1'b1) begin
                vcnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_item: got item=%h elem=%0d last=%b, required no item", o_item, o_elem, o_last);
                end else begin
                    e = sb.pop_front();
                    if (o_item !== e.item || o_elem !== e.elem || o_last !== e.last) begin
                        errors++;
                        $display("FAIL item: got item=%h elem=%0d last=%b, required item=%h elem=%0d last=%b",
                                 o_item, o_elem, o_last, e.item, e.elem, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, required $finish before 300000ns");
        $fatal(1);
    end

    task automatic push(input logic [MASK_W:0] item, input int elem, input bit last);
        exp_t e;
        e.item = item;
        e.elem = EW'(elem);
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic drive_start(input bit masked, indexed, skip, input int vl, vstart, input logic [1:0] eew,
                               input logic [VLEN-1:0] mask, input bit beat_v, last, input logic [VLEN-1:0] beat);
        i_start = 1'b1;
        i_is_masked = masked;
        i_is_indexed = indexed;
        i_skip_inactive = skip;
        i_vl = 9'(vl);
        i_vstart = 9'(vstart);
        i_eew = eew;
        i_mask_data = mask;
        i_index_data_valid = beat_v;
        i_last_index = last;
        i_index_data = beat;
        @(negedge i_clk);
        i_start = 1'b0;
        i_index_data_valid = 1'b0;
        i_last_index = 1'b0;
    endtask

    task automatic send_beat(input logic [VLEN-1:0] beat, input bit last);
        i_index_data = beat;
        i_index_data_valid = 1'b1;
        i_last_index = last;
        @(negedge i_clk);
        i_index_data_valid = 1'b0;
        i_last_index = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge i_clk);
            ok = done_cnt != d0;
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int k = 0; k < VLEN / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, required 0 0 0", o_valid, o_busy, o_done);
        end
        checks++;
        if (o_item !== '0 || o_elem !== '0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: item=%h elem=%0d last=%b, required 0 0 0", o_item, o_elem, o_last);
        end
        checks++;
        if (o_idx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, required 0", o_idx_overflow);
        end
    endtask

    task automatic test_strided;
        logic [VLEN-1:0] v0 = rand_vec();
        int d0 = done_cnt, n0 = vcnt;
        bit ok;
        for (int k = 0; k < 4; k++) push({1'b0, v0[64*k +: 64]}, 0, k == 3);
        drive_start(1, 0, 0, 200, 0, 2'd0, v0, 0, 0, '0);
        wait_done(100, ok);
        repeat (3) @(negedge i_clk);
        checks++;
        if (!ok || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL strided_done: got %0d done pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (vcnt - n0 != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL strided_count: got %0d items (%0d pending), required 4 (0 pending)", vcnt - n0, sb.size());
        end
    endtask

    task automatic test_indexed;
        logic [VLEN-1:0] b0 = rand_vec(), b1 = rand_vec();
        logic [2*VLEN-1:0] buf2 = {b1, b0};
        bit early = 1'b0, ok;
        drive_start(0, 1, 0, 20, 3, 2'd1, '0, 1, 0, b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            early |= o_valid !== 1'b0;
        end
        checks++;
        if (early || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL idx_wait: early_valid=%b busy=%b, required 0 1", early, o_busy);
        end
        for (int e = 3; e < 20; e++) push({1'b1, 48'd0, buf2[16*e +: 16]}, e, e == 19);
        send_beat(b1, 1);
        wait_done(200, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL idx_complete: done=%b pending=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_skip;
        logic [VLEN-1:0] b = rand_vec();
        int n0 = vcnt, d0;
        int el[4] = '{0, 2, 5, 7};
        bit ok;
        foreach (el[k]) push({1'b1, 56'd0, b[8*el[k] +: 8]}, el[k], k == 3);
        drive_start(1, 1, 1, 8, 0, 2'd0, 256'hA5, 1, 1, b);
        wait_done(100, ok);
        checks++;
        if (!ok || vcnt - n0 != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL skip_a5: done=%b items=%0d, required 1 4", ok, vcnt - n0);
        end
        n0 = vcnt;
        d0 = done_cnt;
        drive_start(1, 1, 1, 8, 0, 2'd0, '0, 1, 1, b);
        wait_done(100, ok);
        repeat (3) @(negedge i_clk);
        checks++;
        if (!ok || vcnt != n0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL skip_zero: done_pulses=%0d items=%0d, required 1 0", done_cnt - d0, vcnt - n0);
        end
    endtask

    task automatic test_starvation;
        logic [VLEN-1:0] b = rand_vec();
        bit seen = 1'b0, ok;
        for (int e = 0; e < 32; e++) push({1'b1, 56'd0, b[8*e +: 8]}, e, e == 31);
        drive_start(0, 1, 0, 32, 0, 2'd0, '0, 1, 1, b);
        repeat (6) @(negedge i_clk);
        @(posedge i_clk);
        hold = 1'b1;
        repeat (5) @(negedge i_clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            seen |= o_valid !== 1'b0;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL starve_hold: got o_valid during credit starvation, required 0");
        end
        @(posedge i_clk);
        hold = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL starve_pre: got valid=%b before credit use, required 0", o_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL starve_resume: got valid=%b the cycle after credit, required 1", o_valid);
        end
        wait_done(300, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL starve_complete: done=%b pending=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_overflow_flush;
        logic [VLEN-1:0] beats[9];
        logic [VLEN-1:0] b = rand_vec();
        int d0, n0;
        bit ok;
        foreach (beats[k]) beats[k] = rand_vec();
        drive_start(0, 1, 0, 32, 0, 2'd3, '0, 0, 0, '0);
        for (int k = 0; k < 8; k++) send_beat(beats[k], 0);
        checks++;
        if (o_idx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b after 8 beats, required 0", o_idx_overflow);
        end
        for (int e = 0; e < 32; e++) push({1'b1, beats[e/4][64*(e%4) +: 64]}, e, e == 31);
        send_beat(beats[8], 1);
        checks++;
        if (o_idx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b after 9 beats, required 1", o_idx_overflow);
        end
        repeat (6) @(negedge i_clk);
        d0 = done_cnt;
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        sb.delete();
        n0 = vcnt;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL flush: busy=%b valid=%b done=%b, required 0 0 0", o_busy, o_valid, o_done);
        end
        repeat (5) @(negedge i_clk);
        checks++;
        if (vcnt != n0 || done_cnt != d0 || o_idx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_quiet: items=%0d dones=%0d ovf=%b, required 0 0 1", vcnt - n0, done_cnt - d0, o_idx_overflow);
        end
        for (int e = 0; e < 4; e++) push({1'b1, 56'd0, b[8*e +: 8]}, e, e == 3);
        drive_start(0, 1, 0, 4, 0, 2'd0, '0, 1, 1, b);
        checks++;
        if (o_idx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b after start, required 0", o_idx_overflow);
        end
        wait_done(100, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL post_flush_run: done=%b pending=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_empty;
        int d0 = done_cnt, n0 = vcnt;
        drive_start(1, 0, 0, 5, 5, 2'd0, rand_vec(), 0, 0, '0);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse: done=%b busy=%b, required 1 0", o_done, o_busy);
        end
        repeat (4) @(negedge i_clk);
        checks++;
        if (done_cnt - d0 != 1 || vcnt != n0) begin
            errors++;
            $display("FAIL empty_quiet: dones=%0d items=%0d, required 1 0", done_cnt - d0, vcnt - n0);
        end
    endtask

    task automatic test_reset_mid;
        logic [VLEN-1:0] b = rand_vec();
        int n0;
        bit ok;
        for (int e = 0; e < 32; e++) push({1'b1, 56'd0, b[8*e +: 8]}, e, e == 31);
        drive_start(0, 1, 0, 32, 0, 2'd0, '0, 1, 1, b);
        repeat (6) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        sb.delete();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_item !== '0 || o_elem !== '0 || o_last !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b item=%h elem=%0d last=%b done=%b, required all 0",
                     o_valid, o_busy, o_item, o_elem, o_last, o_done);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        hold = 1'b1;
        @(negedge i_clk);
        n0 = vcnt;
        for (int e = 0; e < 8; e++) push({1'b1, 56'd0, b[8*e +: 8]}, e, e == 7);
        drive_start(0, 1, 0, 8, 0, 2'd0, '0, 1, 1, b);
        repeat (10) @(negedge i_clk);
        checks++;
        if (vcnt - n0 != 2) begin
            errors++;
            $display("FAIL reset_credits: got %0d items with credits held, required 2", vcnt - n0);
        end
        @(posedge i_clk);
        hold = 1'b0;
        @(negedge i_clk);
        wait_done(100, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_resume: done=%b pending=%0d, required 1 0", ok, sb.size());
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_is_masked = 1'b0;
        i_is_indexed = 1'b0;
        i_skip_inactive = 1'b0;
        i_vl = '0;
        i_vstart = '0;
        i_eew = '0;
        i_mask_data = '0;
        i_index_data = '0;
        i_index_data_valid = 1'b0;
        i_last_index = 1'b0;
        i_flush = 1'b0;
        test_reset();
        test_strided();
        test_indexed();
        test_skip();
        test_starvation();
        test_overflow_flush();
        test_empty();
        test_reset_mid();
        repeat (5) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_mask_idx_sequencer.md
Name: tt_mask_idx_sequencer

Overview:
- Streams per-memop mask/index items to the vector memory unit, one item per cycle, under credit flow control.
- Generalises the single-mode mask FSM in four ways:
  - parametrised VLEN, mask word width, index register depth and credit count;
  - vstart-aware element skipping;
  - an optional mode that drops masked-off indexed elements;
  - flush, an overflow flag and a completion pulse.
- Sits between the ID/cracking stage and the VMU memop sequencer.

Parameters:
VLEN, 256, vector register width in bits; the element count is at most VLEN.
MASK_W, 64, number of mask bits per item in strided/unit-stride mode; must divide VLEN.
IDX_REGS, 8, number of index register beats buffered (LMUL max); the buffer holds IDX_REGS*VLEN bits.
MASK_CREDITS, 2, downstream item credits after reset.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  memop sync start; sampled only in IDLE
i_is_masked  in  1  memop is masked (vm=0)
i_is_indexed  in  1  memop is indexed
i_skip_inactive  in  1  indexed only: drop elements whose mask bit is 0
i_vl  in  $clog2(VLEN+1)  vector length
i_vstart  in  $clog2(VLEN+1)  first active element
i_eew  in  2  index EEW: 0=8, 1=16, 2=32, 3=64 bits
i_mask_data  in  VLEN  v0 contents, valid with i_start
i_index_data  in  VLEN  one index register beat
i_index_data_valid  in  1  index beat valid
i_last_index  in  1  qualifies the final index beat; with i_start, no beats follow
i_credit  in  1  one credit returned
i_flush  in  1  abort current memop
o_item  out  MASK_W+1  bit MASK_W = mask bit; [MASK_W-1:0] = index (zero-extended) or mask word
o_valid  out  1  item valid
o_last  out  1  final emitted item of the memop
o_elem  out  $clog2(VLEN)  element number of the indexed item (0 in strided mode)
o_done  out  1  one-cycle pulse when the memop sequence completes
o_busy  out  1  high when state != IDLE
o_idx_overflow  out  1  sticky: more than IDX_REGS index beats received; cleared on i_start

Behaviour:
- Reset: state=IDLE, credits=MASK_CREDITS; all outputs, buffers, pointers and counters at 0.
- Capture on i_start in IDLE with (i_is_masked|i_is_indexed):
  - latch mode, eew and skip;
  - mask buffer = i_mask_data when i_is_masked, else all-ones;
  - bits of elements below vstart are forced to 0.
- Empty memop: if i_vstart >= i_vl, the block stays IDLE and pulses o_done the next cycle; no items are emitted.
- Strided mode:
  - count = ceil(i_vl/MASK_W) - floor(i_vstart/MASK_W);
  - the mask buffer is pre-shifted by floor(vstart/MASK_W)*MASK_W;
  - each emitted item carries the buffer's low MASK_W bits; the buffer then shifts right by MASK_W.
- Indexed mode:
  - count = i_vl - i_vstart; the element pointer starts at i_vstart;
  - index beats write slot wptr (0..IDX_REGS-1); a beat arriving with wptr==IDX_REGS is dropped and sets o_idx_overflow;
  - consumption starts only after the last beat;
  - the buffer is pre-shifted by vstart<<(3+eew) bits when draining begins;
  - each consumed element shifts the index buffer by 8<<eew bits and the mask buffer by 1.
- States:
  - IDLE -> WAIT on a valid start with i_is_indexed & !i_last_index;
  - IDLE -> SEND otherwise;
  - WAIT -> SEND on i_index_data_valid & i_last_index;
  - SEND -> IDLE when count reaches 0 (o_done pulses the same cycle as that transition).
- Consume condition, one element/word per cycle in SEND with count>0:
  - emit = avail>0 & !(skip & indexed & mask bit==0), where avail = credits + i_credit;
  - skip-inactive elements are consumed without a credit and without o_valid.
- Credits: credits_next = credits + i_credit - o_valid.
  - A credit returned in the same cycle may be used.
  - Exceeding MASK_CREDITS is an assertion failure.
- Latency: outputs are registered one cycle after the consume decision.
  - o_last=1 on the item whose consumption leaves no later emittable element.
  - In skip mode this requires a lookahead on the remaining mask bits, so o_last marks the final emitted item.
  - If every element is skipped, no o_last is produced and only o_done pulses.
- Simultaneous i_start and index beat: the beat is written to slot 0.
- i_flush (priority over everything except reset): next cycle the block is IDLE; count, wptr and buffers are cleared; o_valid=0; no o_done. Credits are preserved and still accept returns.
- i_start outside IDLE is ignored.
- Reset mid-operation: full reset values as above, regardless of in-flight items.

Test Plan:
- Strided masked, vl=200, vstart=0, MASK_W=64, credits=2, i_credit returned 2 cycles after each o_valid -> 4 items, each mask word equal to v0 bits [63:0]..[255:192] with bits >=200 unaffected; o_last on item 4; o_done once.
- Indexed, eew=1, vl=20, vstart=3, 2 beats (second with i_last_index) -> 17 items; o_elem 3..19; index = 16-bit slices 3..19 zero-extended; no o_valid before the second beat.
- Indexed with skip, vl=8, mask=0b10100101 -> 4 items at o_elem 0,2,5,7; o_last on elem 7; credits consumed 4. Repeat with mask=0 -> no o_valid, o_done pulse only.
- Credit starvation: credits held at 0 for 10 cycles mid-stream -> o_valid stays low; resumes the cycle after i_credit; no item lost or duplicated.
- 9 index beats with IDX_REGS=8 -> o_idx_overflow=1 and the ninth beat is ignored. i_flush during SEND -> IDLE next cycle, o_valid=0; a subsequent i_start clears the flag and runs normally.
- vstart=vl=5 -> no items, o_done pulse. i_reset asserted mid-SEND -> all outputs 0 and credits=MASK_CREDITS the next cycle.
